// File: rtl/wb_bus_arbiter_if.sv
// Single Wishbone link: master drives request, slave returns data/ack/err.
// The arbiter uses the slave view toward each cache and the master view toward memory.
interface wb_bus_arbiter_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;

   modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
   modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter (m0 ICache, m1 DCache): round-robin, locked for a whole cyc,
// 1-cycle registered grant, combinational data path, ack watchdog aborting dead transfers.
module wb_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   wb_bus_arbiter_if.slave  m0_if,
   wb_bus_arbiter_if.slave  m1_if,
   wb_bus_arbiter_if.master wb_if,
   output logic [1:0]       grant_o
);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_e;

   localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic             last_q, last_d;    // 1: m1 was the most recent owner
   logic [CNT_W-1:0] wdog_q, wdog_d;
   logic             own_cyc, bus_stb, stalled, expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      wdog_d      = '0;
      own_cyc     = 1'b0;
      bus_stb     = 1'b0;
      stalled     = 1'b0;
      expire      = 1'b0;
      grant_o     = 2'b00;
      wb_if.cyc   = 1'b0;
      wb_if.stb   = 1'b0;
      wb_if.we    = 1'b0;
      wb_if.adr   = '0;
      wb_if.dat_w = '0;
      wb_if.sel   = '0;
      m0_if.dat_r = '0;
      m0_if.ack   = 1'b0;
      m0_if.err   = 1'b0;
      m1_if.dat_r = '0;
      m1_if.ack   = 1'b0;
      m1_if.err   = 1'b0;

      case (state_q)
         IDLE: begin
            if (m0_if.cyc && m1_if.cyc) begin
               state_d = last_q ? GNT0 : GNT1;
               last_d  = ~last_q;
            end else if (m0_if.cyc) begin
               state_d = GNT0;
               last_d  = 1'b0;
            end else if (m1_if.cyc) begin
               state_d = GNT1;
               last_d  = 1'b1;
            end
         end

         GNT0, GNT1: begin
            if (state_q == GNT1) begin
               own_cyc     = m1_if.cyc;
               bus_stb     = m1_if.cyc & m1_if.stb;
               wb_if.we    = m1_if.we;
               wb_if.adr   = m1_if.adr;
               wb_if.dat_w = m1_if.dat_w;
               wb_if.sel   = m1_if.sel;
               grant_o     = 2'b10;
            end else begin
               own_cyc     = m0_if.cyc;
               bus_stb     = m0_if.cyc & m0_if.stb;
               wb_if.we    = m0_if.we;
               wb_if.adr   = m0_if.adr;
               wb_if.dat_w = m0_if.dat_w;
               wb_if.sel   = m0_if.sel;
               grant_o     = 2'b01;
            end
            // cyc follows the owner's cyc directly so release takes effect this cycle
            wb_if.cyc   = own_cyc;
            wb_if.stb   = bus_stb;
            m0_if.dat_r = wb_if.dat_r;
            m1_if.dat_r = wb_if.dat_r;

            stalled = bus_stb & ~wb_if.ack & ~wb_if.err;
            expire  = stalled && (wdog_q == WDOG_LIMIT);

            if (state_q == GNT1) begin
               m1_if.ack = wb_if.ack;
               m1_if.err = wb_if.err | expire;
            end else begin
               m0_if.ack = wb_if.ack;
               m0_if.err = wb_if.err | expire;
            end

            if (!own_cyc) begin
               state_d = IDLE;
            end else if (expire) begin
               state_d = ABORT;
            end else if (stalled) begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         ABORT: begin
            // last_q still names the aborted owner; hold the bus until it lets go
            if (!(last_q ? m1_if.cyc : m0_if.cyc)) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed vector table, hand sequences for locking/timeout/reset,
// then random traffic against an owner/stall-count reference model.
module tb_wb_bus_arbiter;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant;

   always #5 clk = ~clk;

   wb_bus_arbiter_if m0_bus ();
   wb_bus_arbiter_if m1_bus ();
   wb_bus_arbiter_if wb_bus ();

   wb_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .m0_if  (m0_bus),
      .m1_if  (m1_bus),
      .wb_if  (wb_bus),
      .grant_o(grant)
   );

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [5:0]  req;    // {m0 cyc, m0 stb, m1 cyc, m1 stb, ack, err}
      logic [31:0] rd;
      logic [1:0]  grant;
      logic        wcyc;
      logic [31:0] wadr;
      logic [3:0]  resp;   // {m1 err, m0 err, m1 ack, m0 ack}
      logic [31:0] dat0;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] resp();
      return {m1_bus.err, m0_bus.err, m1_bus.ack, m0_bus.ack};
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive(input logic [5:0] req, input logic [31:0] rd);
      {m0_bus.cyc, m0_bus.stb, m1_bus.cyc, m1_bus.stb, wb_bus.ack, wb_bus.err} = req;
      wb_bus.dat_r = rd;
   endtask

   task automatic add(input logic [5:0] req, input logic [31:0] rd, input logic [1:0] g,
                      input logic wc, input logic [31:0] wa, input logic [3:0] rs,
                      input logic [31:0] d0);
      vec_t v;
      v.req = req; v.rd = rd; v.grant = g; v.wcyc = wc; v.wadr = wa; v.resp = rs; v.dat0 = d0;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(6'b000000, 32'h0);
      next_cyc();
      next_cyc();
      rst = 1'b0;
   endtask

   task automatic set_fixed();
      m0_bus.we = 1'b0; m0_bus.adr = 32'h8000_0000; m0_bus.dat_w = 32'h0;       m0_bus.sel = 4'hF;
      m1_bus.we = 1'b1; m1_bus.adr = 32'h0000_0100; m1_bus.dat_w = 32'h1234_5678; m1_bus.sel = 4'h3;
   endtask

   // reference model state
   int          owner, last, stalls;
   bit          abrt;
   logic        rc[2], rs[2], rwe[2];
   logic [31:0] radr[2], rdw[2];
   logic [3:0]  rsel[2];

   initial begin
      #400000;
      $display("FAIL global time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0]  own;
      int          idle;
      logic        ack, err, stl, expire;
      logic [31:0] rd;
      logic [1:0]  e_grant;
      logic [70:0] e_bus;
      logic [3:0]  e_resp;
      logic [63:0] e_dat;

      set_fixed();
      // reset holds outputs quiet even with a request and a slave ack present
      rst = 1'b1;
      drive(6'b110010, 32'hA5A5_A5A5);
      next_cyc();
      settle();
      chk("reset grant", grant, 2'b00);
      chk("reset wb_cyc/stb", {wb_bus.cyc, wb_bus.stb}, 2'b00);
      chk("reset resp", resp(), 4'h0);
      chk("reset dat", {m1_bus.dat_r, m0_bus.dat_r}, 64'h0);
      drive(6'b000000, 32'h0);
      next_cyc();
      rst = 1'b0;

      // first tie after reset goes to m1, then m0 after one idle cycle
      add(6'b111100, 32'h0,         2'b00, 1'b0, 32'h0,         4'h0, 32'h0);
      add(6'b111100, 32'h0,         2'b10, 1'b1, 32'h100,       4'h0, 32'h0);
      add(6'b111110, 32'h1111_1111, 2'b10, 1'b1, 32'h100,       4'h2, 32'h1111_1111);
      add(6'b110000, 32'h0,         2'b10, 1'b0, 32'h100,       4'h0, 32'h0);
      add(6'b110000, 32'h0,         2'b00, 1'b0, 32'h0,         4'h0, 32'h0);
      add(6'b110000, 32'h0,         2'b01, 1'b1, 32'h8000_0000, 4'h0, 32'h0);
      add(6'b110010, 32'hDEAD_BEEF, 2'b01, 1'b1, 32'h8000_0000, 4'h1, 32'hDEAD_BEEF);
      add(6'b000000, 32'h0,         2'b01, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
      add(6'b000000, 32'h0,         2'b00, 1'b0, 32'h0,         4'h0, 32'h0);
      // single m0 read, ack on the third bus cycle
      add(6'b110000, 32'h0,         2'b00, 1'b0, 32'h0,         4'h0, 32'h0);
      add(6'b110000, 32'h0,         2'b01, 1'b1, 32'h8000_0000, 4'h0, 32'h0);
      add(6'b110000, 32'h0,         2'b01, 1'b1, 32'h8000_0000, 4'h0, 32'h0);
      add(6'b110010, 32'hDEAD_BEEF, 2'b01, 1'b1, 32'h8000_0000, 4'h1, 32'hDEAD_BEEF);
      add(6'b000000, 32'h0,         2'b01, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
      add(6'b000011, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0,         4'h0, 32'h0);
      // slave error forwarded to m1 only
      add(6'b001100, 32'h0,         2'b00, 1'b0, 32'h0,         4'h0, 32'h0);
      add(6'b001100, 32'h0,         2'b10, 1'b1, 32'h100,       4'h0, 32'h0);
      add(6'b001101, 32'h0,         2'b10, 1'b1, 32'h100,       4'h8, 32'h0);
      add(6'b000000, 32'h0,         2'b10, 1'b0, 32'h100,       4'h0, 32'h0);
      add(6'b000000, 32'h0,         2'b00, 1'b0, 32'h0,         4'h0, 32'h0);

      foreach (tbl[i]) begin
         next_cyc();
         drive(tbl[i].req, tbl[i].rd);
         settle();
         chk($sformatf("vec%0d grant", i), grant, tbl[i].grant);
         chk($sformatf("vec%0d cyc/stb", i), {wb_bus.cyc, wb_bus.stb}, {tbl[i].wcyc, tbl[i].wcyc});
         chk($sformatf("vec%0d adr", i), wb_bus.adr, tbl[i].wadr);
         chk($sformatf("vec%0d resp", i), resp(), tbl[i].resp);
         chk($sformatf("vec%0d dat0", i), m0_bus.dat_r, tbl[i].dat0);
      end

      // alternation under continuous contention
      do_reset();
      for (int t = 0; t < 4; t++) begin
         idle = 0;
         own  = 2'b00;
         for (int k = 0; k < 8 && own == 2'b00; k++) begin
            next_cyc();
            drive(6'b111100, 32'h0);
            settle();
            if (grant == 2'b00) idle++;
            else own = grant;
         end
         chk($sformatf("alt%0d owner", t), own, (t % 2 == 0) ? 2'b10 : 2'b01);
         chk($sformatf("alt%0d idle gap", t), idle, 1);
         wb_bus.ack = 1'b1;
         #1;
         chk($sformatf("alt%0d ack", t), resp(), (own == 2'b10) ? 4'h2 : 4'h1);
         next_cyc();
         drive((own == 2'b10) ? 6'b110000 : 6'b001100, 32'h0);
         settle();
         chk($sformatf("alt%0d release cyc", t), wb_bus.cyc, 1'b0);
      end

      // 8-beat m1 burst stays locked while m0 waits
      own = 2'b00;
      for (int k = 0; k < 8 && own == 2'b00; k++) begin
         next_cyc();
         drive(6'b111100, 32'h0);
         settle();
         own = grant;
      end
      for (int b = 0; b < 8; b++) begin
         if (b > 0) next_cyc();
         drive(6'b111110, 32'h0);
         m1_bus.adr = 32'h100 + 32'(4 * b);
         settle();
         chk($sformatf("burst%0d grant", b), grant, 2'b10);
         chk($sformatf("burst%0d adr", b), {wb_bus.cyc, wb_bus.adr}, {1'b1, 32'h100 + 32'(4 * b)});
         chk($sformatf("burst%0d resp", b), resp(), 4'h2);
      end
      m1_bus.adr = 32'h100;
      next_cyc(); drive(6'b110000, 32'h0); settle();
      chk("burst end cyc", {grant, wb_bus.cyc}, {2'b10, 1'b0});
      next_cyc(); settle();
      chk("burst idle", grant, 2'b00);
      next_cyc(); settle();
      chk("burst m0 after", {grant, wb_bus.adr}, {2'b01, 32'h8000_0000});
      next_cyc(); drive(6'b000000, 32'h0);

      // watchdog expiry on m0, then abort holds off m1
      next_cyc(); drive(6'b110000, 32'h0); settle();
      chk("wd idle", grant, 2'b00);
      for (int s = 1; s <= 4; s++) begin
         next_cyc();
         drive((s >= 2) ? 6'b111100 : 6'b110000, 32'h0);
         settle();
         chk($sformatf("wd stall%0d grant", s), {grant, wb_bus.cyc}, {2'b01, 1'b1});
         chk($sformatf("wd stall%0d resp", s), resp(), (s == 4) ? 4'h4 : 4'h0);
      end
      for (int a = 0; a < 3; a++) begin
         next_cyc();
         drive((a == 1) ? 6'b111110 : 6'b111100, 32'h7777_7777);
         settle();
         chk($sformatf("abort%0d bus", a), {grant, wb_bus.cyc, wb_bus.stb}, 4'b0000);
         chk($sformatf("abort%0d resp", a), resp(), 4'h0);
      end
      next_cyc(); drive(6'b001100, 32'h0); settle();
      chk("abort release", grant, 2'b00);
      next_cyc(); settle();
      chk("post abort idle", grant, 2'b00);
      next_cyc(); settle();
      chk("post abort m1", grant, 2'b10);
      // ack landing on the expiry cycle wins
      for (int s = 2; s <= 5; s++) begin
         next_cyc();
         drive((s == 4) ? 6'b001110 : 6'b001100, 32'h0);
         settle();
         chk($sformatf("ackwin%0d resp", s), resp(), (s == 4) ? 4'h2 : 4'h0);
         chk($sformatf("ackwin%0d grant", s), grant, 2'b10);
      end
      next_cyc(); drive(6'b000000, 32'h0);

      // reset mid-burst
      next_cyc(); drive(6'b001100, 32'h0);
      for (int b = 0; b < 4; b++) begin
         next_cyc();
         drive((b < 3) ? 6'b001110 : 6'b001100, 32'h5555_5555);
         settle();
      end
      chk("pre-rst grant", {grant, wb_bus.cyc}, {2'b10, 1'b1});
      rst = 1'b1;
      #1;
      chk("rst bus", {grant, wb_bus.cyc, wb_bus.stb}, 4'b0000);
      chk("rst resp/dat", {resp(), m0_bus.dat_r, m1_bus.dat_r}, 68'h0);
      drive(6'b000000, 32'h0);
      next_cyc();
      next_cyc();
      rst = 1'b0;
      next_cyc(); drive(6'b110000, 32'h0); settle();
      chk("after rst idle", grant, 2'b00);
      next_cyc(); settle();
      chk("after rst grant", {grant, wb_bus.cyc, wb_bus.adr}, {2'b01, 1'b1, 32'h8000_0000});
      next_cyc(); drive(6'b000000, 32'h0);

      // random traffic against the reference model
      do_reset();
      owner = -1; last = 0; stalls = 0; abrt = 1'b0;
      rc[0] = 1'b0; rc[1] = 1'b0;
      for (int n = 0; n < 600; n++) begin
         next_cyc();
         for (int p = 0; p < 2; p++) begin
            rc[p]   = rc[p] ? ($urandom % 5 != 0) : ($urandom % 3 == 0);
            rs[p]   = ($urandom % 4 != 0);
            rwe[p]  = 1'($urandom);
            radr[p] = $urandom;
            rdw[p]  = $urandom;
            rsel[p] = 4'($urandom);
         end
         ack = ($urandom % 3 == 0);
         err = !ack && ($urandom % 10 == 0);
         rd  = $urandom;
         m0_bus.cyc = rc[0]; m0_bus.stb = rs[0]; m0_bus.we = rwe[0];
         m0_bus.adr = radr[0]; m0_bus.dat_w = rdw[0]; m0_bus.sel = rsel[0];
         m1_bus.cyc = rc[1]; m1_bus.stb = rs[1]; m1_bus.we = rwe[1];
         m1_bus.adr = radr[1]; m1_bus.dat_w = rdw[1]; m1_bus.sel = rsel[1];
         wb_bus.ack = ack; wb_bus.err = err; wb_bus.dat_r = rd;
         settle();

         e_grant = 2'b00; e_bus = '0; e_resp = 4'h0; e_dat = 64'h0;
         if (owner >= 0) begin
            e_grant = (owner == 1) ? 2'b10 : 2'b01;
            e_bus   = {rc[owner], rc[owner] & rs[owner], rwe[owner], radr[owner], rdw[owner], rsel[owner]};
            e_dat   = {rd, rd};
            stl     = rc[owner] && rs[owner] && !ack && !err;
            expire  = stl && (stalls + 1 == TO);
            e_resp[owner]     = ack;
            e_resp[2 + owner] = err || expire;
            if (!rc[owner]) begin
               owner = -1; stalls = 0;
            end else if (expire) begin
               owner = -1; stalls = 0; abrt = 1'b1;
            end else begin
               stalls = stl ? stalls + 1 : 0;
            end
         end else if (abrt) begin
            if (!rc[last]) abrt = 1'b0;
         end else begin
            if (rc[0] && rc[1]) owner = 1 - last;
            else if (rc[0])     owner = 0;
            else if (rc[1])     owner = 1;
            if (owner >= 0) last = owner;
         end

         chk($sformatf("rnd%0d grant", n), grant, e_grant);
         chk($sformatf("rnd%0d bus", n),
             {wb_bus.cyc, wb_bus.stb, wb_bus.we, wb_bus.adr, wb_bus.dat_w, wb_bus.sel}, e_bus);
         chk($sformatf("rnd%0d resp", n), resp(), e_resp);
         chk($sformatf("rnd%0d dat", n), {m1_bus.dat_r, m0_bus.dat_r}, e_dat);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter between the ICache refill port (m0) and the DCache refill/writeback port (m1).
- Arbitrates the single external memory bus behind the top-level caches.
- Round-robin grant, locked for the whole cyc assertion so multi-beat refills are never interleaved.
- Includes an ack watchdog so a dead slave cannot hang the pipeline stall chain.

Parameters:
- TIMEOUT_CYCLES, 255: stb-without-ack cycles before the watchdog aborts the transfer (1..65535).
- CNT_W, 16: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  ICache-side Wishbone request
- m0_adr_i  in  32  address
- m0_dat_i  in  32  write data
- m0_sel_i  in  4  byte select
- m0_dat_o  out  32  read data
- m0_ack_o, m0_err_o  out  1 each  completion / error to ICache
- m1_* : same set as m0_*, DCache side
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  bus master outputs
- wb_adr_o  out  32
- wb_dat_o  out  32
- wb_sel_o  out  4
- wb_dat_i  in  32
- wb_ack_i, wb_err_i  in  1 each  slave response
- grant_o  out  2  one-hot current owner ({m1,m0}), 00 when idle

Behaviour:
- States: IDLE, GNT0, GNT1, ABORT. Reset → IDLE, last_grant=0 (so m1 wins the first tie), watchdog=0.
- Output reset values: all wb_* outputs 0, grant_o=00, m*_ack_o=0, m*_err_o=0, m*_dat_o=0.
- IDLE:
  - Samples m0_cyc_i/m1_cyc_i.
  - Only one asserted → GNT of that port.
  - Both asserted → port ≠ last_grant.
  - Grant is registered: first bus cycle is one clock after cyc is seen, so arbitration latency = 1.
- GNTn:
  - wb_cyc/stb/we/adr/dat/sel = port n inputs, combinationally muxed.
  - grant_o[n]=1; last_grant updated to n on entry.
  - mn_ack_o = wb_ack_i and mn_err_o = wb_err_i. The other port sees ack=err=0.
  - Both m0_dat_o and m1_dat_o carry wb_dat_i (data broadcast; only ack qualifies it).
  - Lock: the state holds while mn_cyc_i=1, regardless of stb toggling or the other port requesting.
  - mn_cyc_i=0 → IDLE next cycle, with wb_cyc_o=0 in that same cycle (combinational from input). Re-arbitration therefore needs one IDLE cycle between owners; no back-to-back handover.
- Watchdog:
  - Counts cycles with wb_stb_o=1 && !wb_ack_i && !wb_err_i.
  - Clears on ack, on err, on stb low, and on any state change.
  - Reaching TIMEOUT_CYCLES → mn_err_o pulses exactly one cycle and the state moves to ABORT. wb_cyc_o/wb_stb_o are 0 from the following cycle.
- ABORT:
  - Bus outputs 0, grant_o=00, acks/errs 0.
  - Waits until the aborted port drops cyc, then → IDLE.
  - The other port is not granted during ABORT.
- Late wb_ack_i/wb_err_i arriving in IDLE or ABORT is ignored (not forwarded).
- ack and watchdog expiry in the same cycle: ack wins, no error.
- cyc drop together with ack in the same cycle: ack is forwarded and the state returns to IDLE.
- rst mid-transfer: immediate return to IDLE with all outputs at reset values. Requesters are reset by the same rst.

Test Plan:
1. Only m0 cyc/stb, read 0x8000_0000, slave acks after 3 cycles with 0xDEADBEEF → grant_o=01 one cycle after request; m0_ack_o one cycle with m0_dat_o=0xDEADBEEF; m1_ack_o never 1.
2. m0 and m1 both request in the same cycle after reset → m1 granted first (grant_o=10). After m1 drops cyc: one IDLE cycle, then grant_o=01.
3. Both hold continuous requests for 4 transactions → grants alternate m1,m0,m1,m0; each handover separated by exactly one idle cycle.
4. m1 holds cyc for an 8-beat burst (adr 0x100..0x11C) while m0 requests throughout → all 8 beats reach the bus unbroken with grant_o=10; m0 is granted only after m1 drops cyc.
5. TIMEOUT_CYCLES=4, slave never acks m0 → m0_err_o pulses at the 4th stalled cycle; wb_cyc_o=0 next cycle; m1 is not granted until m0 drops cyc; a late wb_ack_i is not forwarded.
6. Assert rst during GNT1 beat 3 of a burst → wb_cyc_o=0 and grant_o=00 immediately; after release, a fresh m0 request is granted in 1 cycle.
